// File: rtl/can_destuff_pkg.sv
// Shared types and helpers for the CAN FD receive-path bit destuffer.
package can_destuff_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DYNAMIC     = 2'd1,
        FIXED_STUFF = 2'd2,
        FIXED_DATA  = 2'd3
    } destuff_state_t;

    localparam int unsigned STUFF_LEN_DEF      = 5;
    localparam int unsigned FIXED_INTERVAL_DEF = 4;

    // Returns {gray[2:0], even parity over gray}.
    function automatic logic [3:0] stuff_cnt_encode(input logic [2:0] cnt);
        logic [2:0] g;
        g = cnt ^ (cnt >> 1);
        return {g, ^g};
    endfunction

endpackage

// File: rtl/can_fd_bit_destuff_if.sv
// Sample stream in, destuffed stream and stuff-count status out.
interface can_fd_bit_destuff_if;

    logic       sample_point;
    logic       sampled_bit;
    logic       frame_restart;
    logic       destuff_en;
    logic       fixed_mode;
    logic       bit_valid;
    logic       bit_out;
    logic       stuff_bit;
    logic       stuff_err;
    logic [2:0] stuff_cnt;
    logic [2:0] stuff_cnt_gray;
    logic       stuff_parity;

    modport master (
        output sample_point, sampled_bit, frame_restart, destuff_en, fixed_mode,
        input  bit_valid, bit_out, stuff_bit, stuff_err,
        input  stuff_cnt, stuff_cnt_gray, stuff_parity
    );

    modport slave (
        input  sample_point, sampled_bit, frame_restart, destuff_en, fixed_mode,
        output bit_valid, bit_out, stuff_bit, stuff_err,
        output stuff_cnt, stuff_cnt_gray, stuff_parity
    );

endinterface

// File: rtl/can_stuff_cnt_enc.sv
// Modulo-8 dynamic stuff counter with Gray/parity encoding of the count.
module can_stuff_cnt_enc
    import can_destuff_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [2:0] cnt,
    output logic [2:0] gray,
    output logic       parity
);

    logic [2:0] r_cnt;
    logic [3:0] w_enc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign w_enc  = stuff_cnt_encode(r_cnt);
    assign cnt    = r_cnt;
    assign gray   = w_enc[3:1];
    assign parity = w_enc[0];

endmodule

// File: rtl/can_fd_bit_destuff.sv
// Removes dynamic and fixed CAN FD stuff bits from the sampled bit stream.
module can_fd_bit_destuff
    import can_destuff_pkg::*;
#(
    parameter int unsigned STUFF_LEN      = STUFF_LEN_DEF,
    parameter int unsigned FIXED_INTERVAL = FIXED_INTERVAL_DEF
) (
    input logic                 clk,
    input logic                 rst,
    can_fd_bit_destuff_if.slave bus
);

    localparam int unsigned SW = $clog2(STUFF_LEN + 1);
    localparam int unsigned FW = $clog2(FIXED_INTERVAL + 1);
    localparam logic [SW-1:0] SAME_MAX = SW'(STUFF_LEN);
    localparam logic [FW-1:0] FIX_MAX  = FW'(FIXED_INTERVAL);

    destuff_state_t r_state, w_state_nxt;
    logic [SW-1:0]  r_same_cnt, w_same_nxt;
    logic [FW-1:0]  r_fix_cnt, w_fix_nxt, w_fix_inc;
    logic           r_prev_bit, w_prev_nxt;
    logic           r_bit_valid, w_valid_nxt;
    logic           r_bit_out, w_out_nxt;
    logic           r_stuff_bit, w_stuff_nxt;
    logic           r_stuff_err, w_err_nxt;
    logic           w_cnt_inc;
    logic [2:0]     w_cnt, w_gray;
    logic           w_parity;

    assign w_fix_inc = r_fix_cnt + FW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_same_cnt  <= '0;
            r_fix_cnt   <= '0;
            r_prev_bit  <= 1'b1;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_stuff_bit <= 1'b0;
            r_stuff_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_same_cnt  <= w_same_nxt;
            r_fix_cnt   <= w_fix_nxt;
            r_prev_bit  <= w_prev_nxt;
            r_bit_valid <= w_valid_nxt;
            r_bit_out   <= w_out_nxt;
            r_stuff_bit <= w_stuff_nxt;
            r_stuff_err <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_same_nxt  = r_same_cnt;
        w_fix_nxt   = r_fix_cnt;
        w_prev_nxt  = r_prev_bit;
        w_valid_nxt = 1'b0;
        w_out_nxt   = 1'b0;
        w_stuff_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_inc   = 1'b0;

        if (bus.frame_restart) begin
            w_state_nxt = IDLE;
            w_same_nxt  = '0;
            w_fix_nxt   = '0;
            w_prev_nxt  = 1'b1;
        end else if (bus.sample_point) begin
            if (bus.fixed_mode) begin
                if (r_state == FIXED_DATA) begin
                    w_valid_nxt = 1'b1;
                    w_out_nxt   = bus.sampled_bit;
                    w_prev_nxt  = bus.sampled_bit;
                    w_fix_nxt   = w_fix_inc;
                    if (w_fix_inc >= FIX_MAX) begin
                        w_state_nxt = FIXED_STUFF;
                    end
                // Entry sample is itself the first fixed stuff bit; a pending
                // dynamic stuff is absorbed here and never counted.
                end else if (bus.sampled_bit != r_prev_bit) begin
                    w_stuff_nxt = 1'b1;
                    w_prev_nxt  = bus.sampled_bit;
                    w_fix_nxt   = '0;
                    w_same_nxt  = '0;
                    w_state_nxt = FIXED_DATA;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end else if (bus.destuff_en) begin
                if (r_state != DYNAMIC) begin
                    w_state_nxt = DYNAMIC;
                    w_valid_nxt = 1'b1;
                    w_out_nxt   = bus.sampled_bit;
                    w_prev_nxt  = bus.sampled_bit;
                    w_same_nxt  = SW'(1);
                end else if (r_same_cnt >= SAME_MAX) begin
                    if (bus.sampled_bit != r_prev_bit) begin
                        w_stuff_nxt = 1'b1;
                        w_cnt_inc   = 1'b1;
                        w_same_nxt  = SW'(1);
                        w_prev_nxt  = bus.sampled_bit;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_valid_nxt = 1'b1;
                    w_out_nxt   = bus.sampled_bit;
                    w_prev_nxt  = bus.sampled_bit;
                    w_same_nxt  = (bus.sampled_bit == r_prev_bit) ? r_same_cnt + SW'(1) : SW'(1);
                end
            end else begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b1;
                w_out_nxt   = bus.sampled_bit;
                w_prev_nxt  = bus.sampled_bit;
                w_same_nxt  = '0;
            end
        end
    end

    can_stuff_cnt_enc u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.frame_restart),
        .inc    (w_cnt_inc),
        .cnt    (w_cnt),
        .gray   (w_gray),
        .parity (w_parity)
    );

    assign bus.bit_valid      = r_bit_valid;
    assign bus.bit_out        = r_bit_out;
    assign bus.stuff_bit      = r_stuff_bit;
    assign bus.stuff_err      = r_stuff_err;
    assign bus.stuff_cnt      = w_cnt;
    assign bus.stuff_cnt_gray = w_gray;
    assign bus.stuff_parity   = w_parity;

endmodule

// File: tb/tb_can_fd_bit_destuff.sv
// Scenario bench for the CAN FD bit destuffer with an expected-strobe queue.
module tb_can_fd_bit_destuff;

    typedef struct packed {
        logic v;
        logic o;
        logic s;
        logic e;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic mon_on;
    exp_t exp_q[$];

    can_fd_bit_destuff_if bus ();

    can_fd_bit_destuff #(
        .STUFF_LEN      (5),
        .FIXED_INTERVAL (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every sample_point edge pops one expectation; other edges must be quiet.
    initial begin
        logic sp;
        exp_t e;
        forever begin
            @(posedge clk);
            sp = bus.sample_point;
            #1;
            if (mon_on) begin
                if (sp) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL scoreboard_underflow got v%b s%b e%b with no expectation",
                                 bus.bit_valid, bus.stuff_bit, bus.stuff_err);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.bit_valid, bus.stuff_bit, bus.stuff_err} !== {e.v, e.s, e.e}) begin
                            errors++;
                            $display("FAIL strobes t=%0t got v%b s%b e%b want v%b s%b e%b", $time,
                                     bus.bit_valid, bus.stuff_bit, bus.stuff_err, e.v, e.s, e.e);
                        end
                        if (e.v) begin
                            checks++;
                            if (bus.bit_out !== e.o) begin
                                errors++;
                                $display("FAIL bit_out t=%0t got %b want %b", $time, bus.bit_out, e.o);
                            end
                        end
                    end
                end else begin
                    checks++;
                    if ({bus.bit_valid, bus.stuff_bit, bus.stuff_err} !== 3'b000) begin
                        errors++;
                        $display("FAIL idle_strobes t=%0t got v%b s%b e%b want 000", $time,
                                 bus.bit_valid, bus.stuff_bit, bus.stuff_err);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at a negedge one idle cycle later.
    task automatic drive(input logic b, input logic den, input logic fm, input logic rs,
                         input logic ev, input logic eo, input logic es, input logic ee);
        bus.sampled_bit   = b;
        bus.destuff_en    = den;
        bus.fixed_mode    = fm;
        bus.frame_restart = rs;
        bus.sample_point  = 1'b1;
        exp_q.push_back('{v: ev, o: eo, s: es, e: ee});
        @(negedge clk);
        bus.sample_point  = 1'b0;
        bus.frame_restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic restart();
        bus.frame_restart = 1'b1;
        @(negedge clk);
        bus.frame_restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst               = 1'b0;
        mon_on            = 1'b0;
        bus.sample_point  = 1'b1;
        bus.sampled_bit   = 1'b1;
        bus.frame_restart = 1'b0;
        bus.destuff_en    = 1'b1;
        bus.fixed_mode    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.bit_valid, bus.bit_out, bus.stuff_bit, bus.stuff_err,
             bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs got v%b o%b s%b e%b cnt%0d g%b p%b want all 0",
                     bus.bit_valid, bus.bit_out, bus.stuff_bit, bus.stuff_err,
                     bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity);
        end
        bus.sample_point = 1'b0;
        rst              = 1'b1;
        mon_on           = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_dynamic_stuff();
        restart();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if ({bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity} !== {3'd1, 3'b001, 1'b1}) begin
            errors++;
            $display("FAIL dyn_cnt got cnt%0d g%b p%b want cnt1 g001 p1",
                     bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stuff_error();
        restart();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Back in IDLE: the next destuff sample restarts the run at length 1.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.stuff_cnt !== 3'd1) begin
            errors++;
            $display("FAIL err_recover_cnt got %0d want 1", bus.stuff_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] gray_tab [8];
        logic       v;
        gray_tab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        restart();
        v = 1'b0;
        for (int i = 0; i < 5; i++) drive(v, 1'b1, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            v = ~v;
            drive(v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity} !==
                {3'(k % 8), gray_tab[k % 8], 1'(k % 2)}) begin
                errors++;
                $display("FAIL wrap_cnt event %0d got cnt%0d g%b p%b want cnt%0d g%b p%0d", k,
                         bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity,
                         k % 8, gray_tab[k % 8], k % 2);
            end
            if (k < 9) begin
                for (int i = 0; i < 4; i++) drive(v, 1'b1, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_fixed();
        logic [3:0] data;
        data = 4'b1011;
        restart();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) drive(data[i], 1'b0, 1'b1, 1'b0, 1'b1, data[i], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        restart();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 3; i >= 0; i--) drive(data[i], 1'b0, 1'b1, 1'b0, 1'b1, data[i], 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.stuff_cnt !== 3'd0) begin
            errors++;
            $display("FAIL fixed_cnt got %0d want 0", bus.stuff_cnt);
        end
    endtask

    task automatic test_dyn_to_fixed();
        restart();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.stuff_cnt !== 3'd0) begin
            errors++;
            $display("FAIL absorb_cnt got %0d want 0", bus.stuff_cnt);
        end
    endtask

    task automatic test_restart_coincident();
        restart();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.stuff_cnt !== 3'd0) begin
            errors++;
            $display("FAIL restart_cnt got %0d want 0", bus.stuff_cnt);
        end
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.stuff_cnt !== 3'd1) begin
            errors++;
            $display("FAIL restart_recount got %0d want 1", bus.stuff_cnt);
        end
    endtask

    task automatic test_rst_mid_fixed();
        restart();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        rst              = 1'b0;
        bus.sampled_bit  = 1'b0;
        bus.fixed_mode   = 1'b1;
        bus.sample_point = 1'b1;
        exp_q.push_back('{v: 1'b0, o: 1'b0, s: 1'b0, e: 1'b0});
        @(negedge clk);
        rst              = 1'b1;
        bus.sample_point = 1'b0;
        checks++;
        if ({bus.bit_out, bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity} !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got o%b cnt%0d g%b p%b want all 0",
                     bus.bit_out, bus.stuff_cnt, bus.stuff_cnt_gray, bus.stuff_parity);
        end
        @(negedge clk);
        // Reset leaves IDLE with prev=1, so a fixed-mode 1 is an illegal stuff bit.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_passthrough();
        test_dynamic_stuff();
        test_stuff_error();
        test_wrap();
        test_fixed();
        test_dyn_to_fixed();
        test_restart_coincident();
        test_rst_mid_fixed();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
